// File: rtl/serial_subtractor.sv
// Bit-serial add/subtract unit: processes one operand bit per clock, LSB first,
// and publishes result, borrow/carry, zero and signed overflow together on completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow,
    output logic [1:0]       dbg_state_o
);

    // Handshake: start is a request taken only in IDLE (operands captured on that edge);
    // busy is high for the WIDTH bit-cycles; done is a single-cycle completion strobe.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic bit_a, bit_b, bit_x, bit_s, c_next, last_bit;

    always_comb begin
        bit_a    = a_q[0];
        bit_b    = b_q[0];
        bit_x    = bit_a ^ bit_b;
        bit_s    = bit_x ^ c_q;
        c_next   = mode_q ? ((bit_a & bit_b) | (bit_x & c_q))
                          : ((~bit_a & bit_b) | (~bit_x & c_q));
        last_bit = (cnt_q == CW'(WIDTH - 1));

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        mode_d   = mode_q;
        result_d = result_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = op_a;
                    b_d     = op_b;
                    mode_d  = mode;
                    c_d     = borrow_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                c_d              = c_next;
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = bit_s;
                cnt_d            = cnt_q + CW'(1);
                if (last_bit) begin
                    // On the final bit a_q[0]/b_q[0] are the operand sign bits.
                    state_d  = S_DONE;
                    result_d = acc_d;
                    bout_d   = c_next;
                    zero_d   = (acc_d == '0);
                    ovf_d    = mode_q ? ((bit_a == bit_b) && (bit_s != bit_a))
                                      : ((bit_a != bit_b) && (bit_s != bit_a));
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            mode_q   <= 1'b0;
            result_q <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign borrow_out  = bout_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for arithmetic, latency,
// mid-run disturbance and reset abort, and a 1-bit instance for the full-subtractor table.
module tb_serial_subtractor;

    logic clk;
    logic rst;

    logic       start8, mode8, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8, zero8, ovf8;
    logic [7:0] res8;
    logic [1:0] st8;

    logic       start1, mode1, bin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, bo1, zero1, ovf1;
    logic [0:0] res1;
    logic [1:0] st1;

    int total_cnt = 0;
    int pass_cnt  = 0;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8),
        .op_a(a8), .op_b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .result(res8), .borrow_out(bo8),
        .zero(zero8), .overflow(ovf8), .dbg_state_o(st8)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1),
        .op_a(a1), .op_b(b1), .borrow_in(bin1),
        .busy(busy1), .done(done1), .result(res1), .borrow_out(bo1),
        .zero(zero1), .overflow(ovf1), .dbg_state_o(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic launch8(input logic m, input logic [7:0] a, input logic [7:0] b,
                           input logic bi);
        mode8  = m;
        a8     = a;
        b8     = b;
        bin8   = bi;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
    endtask

    task automatic do_op8(input string tag, input logic m, input logic [7:0] a,
                          input logic [7:0] b, input logic bi, input logic [7:0] er,
                          input logic ebo, input logic ez, input logic eov);
        int   lat;
        logic busy_ok;
        launch8(m, a, b, bi);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done8 && lat < 40) begin
            if (!busy8) busy_ok = 1'b0;
            step();
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'd8);
        check({tag, "/busy"}, 64'(busy_ok), 64'd1);
        check({tag, "/result"}, 64'(res8), 64'(er));
        check({tag, "/borrow_out"}, 64'(bo8), 64'(ebo));
        check({tag, "/zero"}, 64'(zero8), 64'(ez));
        check({tag, "/overflow"}, 64'(ovf8), 64'(eov));
        step();
        check({tag, "/done_pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        int         dcnt;
        int         dlat;
        logic [7:0] dres;
        int         lat;
        logic [2:0] vv;
        logic [1:0] exp1 [8];

        exp1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; bin8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; mode1 = 1'b0; bin1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) step();

        check("reset/busy", 64'(busy8), 64'd0);
        check("reset/done", 64'(done8), 64'd0);
        check("reset/result", 64'(res8), 64'd0);
        check("reset/borrow_out", 64'(bo8), 64'd0);
        check("reset/zero", 64'(zero8), 64'd1);
        check("reset/overflow", 64'(ovf8), 64'd0);
        rst = 1'b0;
        step();

        do_op8("sub_05_03", 1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        do_op8("sub_03_05", 1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        do_op8("sub_80_01", 1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        do_op8("add_FF_01", 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        do_op8("add_7F_01", 1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
        do_op8("sub_00_00_bin", 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op8("add_40_30_cin", 1'b1, 8'h40, 8'h30, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0);

        // Disturb start and operands while the 0x10 - 0x01 operation runs.
        launch8(1'b0, 8'h10, 8'h01, 1'b0);
        dcnt = 0; dlat = -1; dres = '0;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; mode8 = 1'b1; bin8 = 1'b1;
            end
            if (k == 6) start8 = 1'b0;
            if (done8) begin
                dcnt++;
                dres = res8;
                dlat = k;
            end
            step();
        end
        check("midrun/done_count", 64'(dcnt), 64'd1);
        check("midrun/result", 64'(dres), 64'h0F);
        check("midrun/latency", 64'(dlat), 64'd8);

        // Start held high: two complete operations, each with one done pulse.
        launch8(1'b0, 8'h05, 8'h03, 1'b0);
        start8 = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 26; k++) begin
            if (k == 10) start8 = 1'b0;
            if (done8) begin
                dcnt++;
                check("held/result", 64'(res8), 64'h02);
            end
            step();
        end
        check("held/done_count", 64'(dcnt), 64'd2);

        // Reset during bit 4 aborts the operation without a done pulse.
        launch8(1'b0, 8'h33, 8'h11, 1'b0);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort/busy", 64'(busy8), 64'd0);
        check("abort/done", 64'(done8), 64'd0);
        check("abort/result", 64'(res8), 64'd0);
        check("abort/borrow_out", 64'(bo8), 64'd0);
        check("abort/zero", 64'(zero8), 64'd1);
        check("abort/overflow", 64'(ovf8), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8) dcnt++;
            step();
        end
        check("abort/no_done", 64'(dcnt), 64'd0);
        do_op8("after_abort", 1'b0, 8'h22, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);

        // Single-bit full-subtractor truth table.
        for (int v = 0; v < 8; v++) begin
            vv     = 3'(v);
            a1     = vv[2];
            b1     = vv[1];
            bin1   = vv[0];
            mode1  = 1'b0;
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            lat = 0;
            while (!done1 && lat < 10) begin
                step();
                lat++;
            end
            check($sformatf("w1_v%0d/latency", v), 64'(lat), 64'd1);
            check($sformatf("w1_v%0d/result_borrow", v), 64'({res1, bo1}), 64'(exp1[v]));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
